// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter / fetch sequencer.
package pc_seq_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } seq_state_e;

endpackage

// File: rtl/if_buf_reg.sv
// One-entry IF buffer holding a fetched instruction and its PC for decode.
module if_buf_reg
    import pc_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_pc_i,
    input  logic [XLEN-1:0] load_instr_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] instr_q;

    // Flush wins over everything; load and pop never coincide by construction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= XLEN'(NOP_INSTR);
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= load_pc_i;
            instr_q <= load_instr_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              BOOT_CYCLES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            trap_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            if_valid_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [XLEN-1:0] if_instr_o,
    input  logic            if_ready_i,
    output logic            flush_o,
    output logic            misalign_o
);

    localparam int CNT_W = $clog2(BOOT_CYCLES + 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  pc_q, pc_d;

    logic            redirect_any;
    logic            active;
    logic [XLEN-1:0] target_pc;
    logic            buf_valid;
    logic            buf_load;

    assign redirect_any = trap_i | redirect_i;
    assign active       = (state_q != ST_BOOT);
    assign target_pc    = trap_i ? TRAP_VECTOR : {redirect_pc_i[XLEN-1:2], 2'b00};

    assign flush_o     = active & redirect_any;
    assign misalign_o  = active & redirect_i & ~trap_i & (|redirect_pc_i[1:0]);
    assign imem_addr_o = pc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        imem_req_o = 1'b0;
        buf_load   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                // Leave BOOT as the counter reaches zero so BOOT_CYCLES idle cycles elapse.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (redirect_any) begin
                    pc_d = target_pc;
                end else if (!buf_valid || if_ready_i) begin
                    imem_req_o = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack_i) begin
                    state_d = ST_ISSUE;
                    if (redirect_any) begin
                        pc_d = target_pc;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + XLEN'(4);
                    end
                end else if (redirect_any) begin
                    pc_d    = target_pc;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The in-flight word belongs to a dead path; swallow its ack.
                if (redirect_any) begin
                    pc_d = target_pc;
                end
                if (imem_ack_i) begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            cnt_q   <= CNT_W'(BOOT_CYCLES);
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    if_buf_reg #(
        .XLEN (XLEN)
    ) u_if_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (buf_load),
        .load_pc_i    (pc_q),
        .load_instr_i (imem_rdata_i),
        .pop_i        (buf_valid & if_ready_i),
        .flush_i      (flush_o),
        .valid_o      (buf_valid),
        .pc_o         (if_pc_o),
        .instr_o      (if_instr_o)
    );

    assign if_valid_o = buf_valid;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized and directed bench for pc_fetch_sequencer against a behavioural fetch model.
module tb_pc_fetch_sequencer;

    localparam int BOOT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        if_ready_i = 1'b0;
    logic        flush_o;
    logic        misalign_o;

    pc_fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .trap_i        (trap_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .if_ready_i    (if_ready_i),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: idle countdown, one outstanding fetch, optional "stale" mark, one-slot buffer.
    int          m_boot;
    bit          m_out, m_stale, m_bv;
    logic [31:0] m_pc, m_bpc, m_bi;

    // Memory responder
    bit          mem_pending = 0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = '0;
    int          mem_lat = 1;
    bit          rand_lat = 0;
    logic [31:0] last_ack_data = '0;

    // Observed values of the last stepped cycle
    bit          obs_req, obs_flush, obs_mis, obs_valid;
    logic [31:0] obs_addr, obs_ifpc, obs_instr;
    int          wcycles;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = BOOT;
        m_out   = 0;
        m_stale = 0;
        m_pc    = 32'h0;
        m_bv    = 0;
        m_bpc   = 32'h0;
        m_bi    = 32'h0000_0013;
    endtask

    task automatic step(input bit rst, input bit trp, input bit rdr,
                        input logic [31:0] rpc, input bit rdy);
        logic [31:0] tgt;
        bit act, e_flush, e_mis, e_req, land;
        @(negedge clk);
        rst_n         = ~rst;
        trap_i        = trp;
        redirect_i    = rdr;
        redirect_pc_i = rpc;
        if_ready_i    = rdy;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = $urandom;
        if (mem_pending) begin
            if (mem_cnt <= 1) begin
                imem_ack_i    = 1'b1;
                imem_rdata_i  = mem_data;
                last_ack_data = mem_data;
                mem_pending   = 0;
            end else begin
                mem_cnt--;
            end
        end
        #1;
        obs_req   = imem_req_o;
        obs_addr  = imem_addr_o;
        obs_flush = flush_o;
        obs_mis   = misalign_o;
        obs_valid = if_valid_o;
        obs_ifpc  = if_pc_o;
        obs_instr = if_instr_o;
        if (rst) begin
            model_reset();
        end else begin
            act     = (m_boot == 0);
            tgt     = trp ? 32'h0000_0100 : {rpc[31:2], 2'b00};
            e_flush = act && (trp || rdr);
            e_mis   = act && rdr && !trp && (rpc[1:0] != 2'b00);
            e_req   = act && !m_out && !e_flush && (!m_bv || rdy);
            check_eq("req",   {31'b0, obs_req},   {31'b0, e_req});
            check_eq("addr",  obs_addr,           m_pc);
            check_eq("flush", {31'b0, obs_flush}, {31'b0, e_flush});
            check_eq("mis",   {31'b0, obs_mis},   {31'b0, e_mis});
            check_eq("valid", {31'b0, obs_valid}, {31'b0, m_bv});
            check_eq("if_pc", obs_ifpc,           m_bpc);
            check_eq("instr", obs_instr,          m_bi);
            if (!act) begin
                m_boot--;
            end else begin
                land = m_out && imem_ack_i;
                if (e_flush) begin
                    m_bv = 0;
                    m_pc = tgt;
                    if (land) begin
                        m_out   = 0;
                        m_stale = 0;
                    end else if (m_out) begin
                        m_stale = 1;
                    end
                end else begin
                    if (land) begin
                        if (!m_stale) begin
                            m_bv  = 1;
                            m_bpc = m_pc;
                            m_bi  = imem_rdata_i;
                            m_pc  = m_pc + 32'd4;
                        end
                        m_out   = 0;
                        m_stale = 0;
                    end else if (m_bv && rdy) begin
                        m_bv = 0;
                    end
                    if (e_req) begin
                        m_out   = 1;
                        m_stale = 0;
                    end
                end
            end
            if (obs_req) begin
                mem_pending = 1;
                mem_cnt     = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
                mem_data    = $urandom;
                $display("req addr=%h lat=%0d data=%h", obs_addr, mem_cnt, mem_data);
            end
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr, input int budget);
        bit got;
        got     = 0;
        wcycles = 0;
        for (int i = 0; i < budget && !got; i++) begin
            step(0, 0, 0, 32'h0, 1);
            wcycles++;
            if (obs_req) got = 1;
        end
        check_eq({tag, "_seen"}, {31'b0, got}, 32'd1);
        if (got) check_eq({tag, "_addr"}, obs_addr, exp_addr);
    endtask

    initial begin
        model_reset();
        step(1, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0, 0);

        // Boot and straight-line fetch with 1-cycle memory
        mem_lat = 1;
        wait_req("t1_first", 32'h0, 10);
        check_eq("t1_boot_cycles", wcycles, 3);
        wait_req("t1_second", 32'h4, 5);
        check_eq("t1_ifpc0", obs_ifpc, 32'h0);
        wait_req("t1_third", 32'h8, 5);
        check_eq("t1_ifpc4", obs_ifpc, 32'h4);

        // Decode stalls: no request while buffer is full
        step(0, 0, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        check_eq("t2_noreq_a", {31'b0, obs_req}, 32'd0);
        check_eq("t2_ifpc8", obs_ifpc, 32'h8);
        step(0, 0, 0, 32'h0, 0);
        check_eq("t2_noreq_b", {31'b0, obs_req}, 32'd0);
        check_eq("t2_instr_hold", obs_instr, last_ack_data);
        mem_lat = 3;
        step(0, 0, 0, 32'h0, 1);
        check_eq("t2_req_on_ready", {31'b0, obs_req}, 32'd1);
        check_eq("t2_addr", obs_addr, 32'hC);

        // Redirect while waiting on a slow fetch
        step(0, 0, 1, 32'h200, 1);
        check_eq("t3_flush", {31'b0, obs_flush}, 32'd1);
        mem_lat = 1;
        wait_req("t3_redir", 32'h200, 6);
        check_eq("t3_stale_dropped", {31'b0, obs_valid}, 32'd0);

        // Trap beats redirect
        step(0, 0, 0, 32'h0, 1);
        step(0, 1, 1, 32'h80, 1);
        check_eq("t4_flush", {31'b0, obs_flush}, 32'd1);
        check_eq("t4_mis", {31'b0, obs_mis}, 32'd0);
        wait_req("t4_trap", 32'h100, 4);

        // Misaligned target is flagged and aligned
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'h203, 1);
        check_eq("t5_mis", {31'b0, obs_mis}, 32'd1);
        wait_req("t5_align", 32'h200, 4);

        // PC wrap, then reset during a slow fetch
        step(0, 0, 0, 32'h0, 1);
        step(0, 0, 1, 32'hFFFF_FFFC, 1);
        wait_req("t6_top", 32'hFFFF_FFFC, 4);
        step(0, 0, 0, 32'h0, 1);
        mem_lat = 3;
        wait_req("t6_wrap", 32'h0, 4);
        step(1, 0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 1);
        check_eq("t6_rst_valid", {31'b0, obs_valid}, 32'd0);
        check_eq("t6_rst_instr", obs_instr, 32'h0000_0013);
        check_eq("t6_rst_ifpc", obs_ifpc, 32'h0);
        check_eq("t6_rst_req", {31'b0, obs_req}, 32'd0);
        wait_req("t6_reboot", 32'h0, 6);
        check_eq("t6_boot_cycles", wcycles, 2);

        // Randomized traffic
        rand_lat = 1;
        for (int i = 0; i < 3000; i++) begin
            bit          r_rst, r_trp, r_rdr, r_rdy;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(0, 199) == 0);
            r_trp = ($urandom_range(0, 19) == 0);
            r_rdr = ($urandom_range(0, 4) == 0);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_3FFF);
            step(r_rst, r_trp, r_rdr, r_pc, r_rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
